fifo_rd_burst: RTL and testbench

FIFO_RD_BURST -- requirements
Module: fifo_rd_burst

---
 rtl/fifo_rd_burst.sv | 126 ++++++++++++
 tb/tb_fifo_rd_burst.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_burst.sv
// Burst reader: pops a programmed number of words from a FIFO read port and
// streams them out through a 2-entry skid buffer with valid/ready handshake.
module fifo_rd_burst #(
    parameter int DSIZE = 8,
    parameter int CSIZE = 8
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    input  logic             start,
    input  logic [CSIZE-1:0] burst_len,
    input  logic             abort,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic [CSIZE-1:0] rd_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_reg;
    logic [CSIZE-1:0] remaining_reg;
    logic [CSIZE-1:0] rd_count_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [1:0]       occ_reg;
    logic [1:0]       occ_next;
    logic [DSIZE-1:0] buf0_reg;
    logic [DSIZE-1:0] buf1_reg;
    logic             push;
    logic             pop;
    logic             wr_slot1;

    // Pop strobe is kept combinational so the FIFO head is captured on the same edge.
    assign push = (state_reg == RUN) && !rempty && (remaining_reg != '0)
                  && (occ_reg < 2'd2) && !abort && !rrst;
    assign pop  = (occ_reg != 2'd0) && m_ready;

    // A pushed word lands behind whatever remains after this cycle's pop.
    assign wr_slot1 = (occ_reg == 2'd1) && !pop;
    assign occ_next = occ_reg + {1'b0, push} - {1'b0, pop};

    assign rinc     = push;
    assign m_data   = buf0_reg;
    assign m_valid  = (occ_reg != 2'd0);
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign rd_count = rd_count_reg;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            occ_reg  <= 2'd0;
            buf0_reg <= '0;
            buf1_reg <= '0;
        end else begin
            occ_reg <= occ_next;
            if (push && !wr_slot1) begin
                buf0_reg <= rdata;
            end else if (pop) begin
                buf0_reg <= buf1_reg;
            end
            if (push && wr_slot1) begin
                buf1_reg <= rdata;
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            rd_count_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        rd_count_reg <= '0;
                        if (burst_len != '0) begin
                            remaining_reg <= burst_len;
                            busy_reg      <= 1'b1;
                            state_reg     <= RUN;
                        end else begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (push) begin
                        remaining_reg <= remaining_reg - CSIZE'(1);
                        rd_count_reg  <= rd_count_reg + CSIZE'(1);
                    end
                    if (abort || (push && remaining_reg == CSIZE'(1))) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (occ_next == 2'd0) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_burst.sv
// Directed bench for fifo_rd_burst: a queue-backed FIFO model feeds the DUT and a
// forked monitor checks every stream transfer against a scoreboard queue.
module tb_fifo_rd_burst;

    logic       rclk = 1'b0;
    logic       rrst;
    logic [7:0] rdata;
    logic       rempty;
    logic       rinc;
    logic       start;
    logic [7:0] burst_len;
    logic       abort;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       busy;
    logic       done;
    logic [7:0] rd_count;

    logic [7:0] mem [0:63];
    int         wptr = 0;
    int         rptr = 0;
    logic       fifo_clr = 1'b0;

    int pop_cnt  = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] exp_q [$];

    fifo_rd_burst #(.DSIZE(8), .CSIZE(8)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rdata     (rdata),
        .rempty    (rempty),
        .rinc      (rinc),
        .start     (start),
        .burst_len (burst_len),
        .abort     (abort),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done),
        .rd_count  (rd_count)
    );

    always #5 rclk = ~rclk;

    assign rdata  = mem[rptr % 64];
    assign rempty = (wptr == rptr);

    always @(posedge rclk) begin
        if (fifo_clr) rptr <= wptr;
        else if (rinc) rptr <= rptr + 1;
        if (rinc) pop_cnt <= pop_cnt + 1;
        if (m_valid && m_ready && !rrst) xfer_cnt <= xfer_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic monitor();
        logic [7:0] prev_data = '0;
        logic       prev_hold = 1'b0;
        logic [7:0] e;
        forever begin
            @(negedge rclk);
            if (prev_hold && m_valid) chk("hold_stable", int'(m_data), int'(prev_data));
            if (!rrst && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", int'(m_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    $display("xfer data=0x%02h expected=0x%02h", m_data, e);
                    chk("xfer_data", int'(m_data), int'(e));
                end
            end
            prev_hold = m_valid && !m_ready && !rrst;
            prev_data = m_data;
        end
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic fifo_write(input logic [7:0] v, input bit expect_out);
        mem[wptr % 64] = v;
        wptr = wptr + 1;
        if (expect_out) exp_q.push_back(v);
    endtask

    task automatic start_burst(input logic [7:0] len);
        start = 1'b1;
        burst_len = len;
        step();
        start = 1'b0;
        burst_len = 8'd0;
    endtask

    // Leaves the caller at the negedge of the cycle where done is high.
    task automatic wait_done(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge rclk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, int'(ok), 1);
    endtask

    task automatic flush_fifo();
        fifo_clr = 1'b1;
        step();
        fifo_clr = 1'b0;
    endtask

    initial begin
        int p0;
        int d0;
        int x0;
        logic [7:0] v;
        rrst = 1'b1;
        start = 1'b0;
        burst_len = 8'd0;
        abort = 1'b0;
        m_ready = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge rclk);
        #1;
        rrst = 1'b0;
        @(negedge rclk);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rinc", int'(rinc), 0);
        chk("rst_rd_count", int'(rd_count), 0);
        step();

        // Basic 3-word burst at full throughput.
        m_ready = 1'b1;
        fifo_write(8'h11, 1'b1);
        fifo_write(8'h22, 1'b1);
        fifo_write(8'h33, 1'b1);
        p0 = pop_cnt; d0 = done_cnt; x0 = xfer_cnt;
        start_burst(8'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_rinc_consec", int'(rinc), 1);
            step();
        end
        chk("t1_rinc_end", int'(rinc), 0);
        wait_done("t1_done_seen", 20);
        chk("t1_busy_at_done", int'(busy), 0);
        chk("t1_rd_count", int'(rd_count), 3);
        step();
        step();
        chk("t1_pops", pop_cnt - p0, 3);
        chk("t1_xfers", xfer_cnt - x0, 3);
        chk("t1_done_pulses", done_cnt - d0, 1);

        // Backpressure: buffer fills to 2 and holds.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = 8'h41 + 8'(i);
            fifo_write(v, 1'b1);
        end
        p0 = pop_cnt;
        start_burst(8'd4);
        repeat (6) step();
        chk("t2_pops_stalled", pop_cnt - p0, 2);
        chk("t2_rinc_stalled", int'(rinc), 0);
        chk("t2_m_valid", int'(m_valid), 1);
        chk("t2_m_data_head", int'(m_data), 8'h41);
        chk("t2_busy", int'(busy), 1);
        m_ready = 1'b1;
        wait_done("t2_done_seen", 20);
        chk("t2_rd_count", int'(rd_count), 4);
        chk("t2_pops", pop_cnt - p0, 4);
        step();

        // FIFO runs dry mid-burst, then refills.
        fifo_write(8'h51, 1'b1);
        fifo_write(8'h52, 1'b1);
        p0 = pop_cnt; d0 = done_cnt; x0 = xfer_cnt;
        start_burst(8'd5);
        repeat (6) step();
        chk("t3_pops_dry", pop_cnt - p0, 2);
        chk("t3_busy_dry", int'(busy), 1);
        chk("t3_no_done_dry", done_cnt - d0, 0);
        fifo_write(8'h53, 1'b1);
        fifo_write(8'h54, 1'b1);
        fifo_write(8'h55, 1'b1);
        wait_done("t3_done_seen", 20);
        chk("t3_rd_count", int'(rd_count), 5);
        step();
        chk("t3_pops", pop_cnt - p0, 5);
        chk("t3_xfers", xfer_cnt - x0, 5);

        // Abort after the third pop.
        for (int i = 0; i < 10; i++) begin
            v = 8'hA0 + 8'(i);
            fifo_write(v, i < 3);
        end
        p0 = pop_cnt; d0 = done_cnt;
        start_burst(8'd10);
        for (int i = 0; i < 20; i++) begin
            if (pop_cnt - p0 >= 3) break;
            step();
        end
        abort = 1'b1;
        #1;
        chk("t4_rinc_abort", int'(rinc), 0);
        step();
        abort = 1'b0;
        wait_done("t4_done_seen", 20);
        chk("t4_rd_count", int'(rd_count), 3);
        step();
        step();
        chk("t4_pops", pop_cnt - p0, 3);
        chk("t4_done_pulses", done_cnt - d0, 1);
        flush_fifo();

        // Zero-length burst.
        fifo_write(8'hEE, 1'b0);
        p0 = pop_cnt;
        start_burst(8'd0);
        wait_done("t5_done_next", 1);
        chk("t5_rd_count", int'(rd_count), 0);
        step();
        step();
        chk("t5_pops", pop_cnt - p0, 0);
        flush_fifo();

        // Reset with two words buffered mid-burst.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = 8'h61 + 8'(i);
            fifo_write(v, 1'b0);
        end
        p0 = pop_cnt;
        start_burst(8'd4);
        repeat (4) step();
        chk("t6_pops_before_rst", pop_cnt - p0, 2);
        rrst = 1'b1;
        step();
        rrst = 1'b0;
        chk("t6_m_valid", int'(m_valid), 0);
        chk("t6_m_data", int'(m_data), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_rinc", int'(rinc), 0);
        chk("t6_rd_count", int'(rd_count), 0);
        p0 = pop_cnt;
        repeat (3) step();
        chk("t6_no_pops_after_rst", pop_cnt - p0, 0);
        flush_fifo();
        m_ready = 1'b1;
        fifo_write(8'h71, 1'b1);
        fifo_write(8'h72, 1'b1);
        start_burst(8'd2);
        wait_done("t6_restart_done", 20);
        chk("t6_restart_rd_count", int'(rd_count), 2);

        repeat (3) step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
